interval_store: RTL and testbench



---
 rtl/interval_store.sv | 150 +++++++++++++++
 tb/tb_interval_store.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/interval_store.sv
// interval_store
// Holds the most recent DEPTH closed byte-address intervals [first, last] in a
// circular buffer and answers, every cycle, whether the query address lies
// inside a stored interval or on the byte immediately before one.
// Writes are validated: malformed intervals are dropped and duplicates are
// suppressed. When the buffer is full the oldest entry is overwritten.
//
// Ports:
//   clk_i           clock
//   rst_i           asynchronous reset, active-high
//   en_write_i      single-cycle write request
//   addr_first_i    first byte of interval to write
//   addr_last_i     last byte of interval to write (inclusive)
//   flush_i         invalidate all entries (wins over a simultaneous write)
//   current_addr_i  query address
//   addr_in_range_o query hits inside a valid entry (combinational)
//   addr_is_first_o query + 1 equals the first byte of a valid entry (combinational)
//   count_o         number of valid entries (registered)
//   full_o          count_o == DEPTH (registered)
//   drop_o          pulse: previous write was malformed
//   overwrite_o     pulse: previous write evicted the oldest entry
module interval_store #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 32
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       en_write_i,
    input  logic [ADDR_W-1:0]          addr_first_i,
    input  logic [ADDR_W-1:0]          addr_last_i,
    input  logic                       flush_i,
    input  logic [ADDR_W-1:0]          current_addr_i,
    output logic                       addr_in_range_o,
    output logic                       addr_is_first_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       full_o,
    output logic                       drop_o,
    output logic                       overwrite_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [ADDR_W-1:0] first_q [DEPTH];
    logic [ADDR_W-1:0] first_d [DEPTH];
    logic [ADDR_W-1:0] last_q  [DEPTH];
    logic [ADDR_W-1:0] last_d  [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              full_q, full_d;
    logic              drop_q, drop_d;
    logic              overwrite_q, overwrite_d;

    logic              in_range_s;
    logic              is_first_s;
    logic [ADDR_W-1:0] addr_next_s;
    logic              dup_s;
    logic              malformed_s;

    // Query lookup: OR of per-entry hits; addr+1 wraps so all-ones matches first==0.
    always_comb begin
        in_range_s  = 1'b0;
        is_first_s  = 1'b0;
        addr_next_s = current_addr_i + ADDR_W'(1);
        for (int k = 0; k < DEPTH; k++) begin
            in_range_s = in_range_s | (valid_q[k] & (first_q[k] <= current_addr_i)
                                                  & (current_addr_i <= last_q[k]));
            is_first_s = is_first_s | (valid_q[k] & (addr_next_s == first_q[k]));
        end
    end

    // Write classification against pre-edge contents.
    always_comb begin
        malformed_s = (addr_last_i < addr_first_i);
        dup_s       = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            dup_s = dup_s | (valid_q[k] & (first_q[k] == addr_first_i)
                                        & (last_q[k] == addr_last_i));
        end
    end

    // Next-state: flush beats write; a full buffer overwrites the slot at wr_ptr (the oldest).
    always_comb begin
        valid_d     = valid_q;
        first_d     = first_q;
        last_d      = last_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        drop_d      = 1'b0;
        overwrite_d = 1'b0;
        if (flush_i) begin
            valid_d  = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else if (en_write_i) begin
            if (malformed_s) begin
                drop_d = 1'b1;
            end else if (!dup_s) begin
                first_d[wr_ptr_q] = addr_first_i;
                last_d[wr_ptr_q]  = addr_last_i;
                valid_d[wr_ptr_q] = 1'b1;
                wr_ptr_d          = wr_ptr_q + PTR_W'(1);
                if (full_q) begin
                    overwrite_d = 1'b1;
                end else begin
                    count_d = count_q + CNT_W'(1);
                end
            end else begin
                drop_d = 1'b0;
            end
        end else begin
            drop_d = 1'b0;
        end
        full_d = (count_d == CNT_W'(DEPTH));
    end

    // Control and status registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q     <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            full_q      <= 1'b0;
            drop_q      <= 1'b0;
            overwrite_q <= 1'b0;
        end else begin
            valid_q     <= valid_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            full_q      <= full_d;
            drop_q      <= drop_d;
            overwrite_q <= overwrite_d;
        end
    end

    // Entry payloads need no reset: they are meaningless while the valid bit is clear.
    always_ff @(posedge clk_i) begin
        first_q <= first_d;
        last_q  <= last_d;
    end

    assign addr_in_range_o = in_range_s;
    assign addr_is_first_o = is_first_s;
    assign count_o         = count_q;
    assign full_o          = full_q;
    assign drop_o          = drop_q;
    assign overwrite_o     = overwrite_q;

endmodule

// File: tb/tb_interval_store.sv
module tb_interval_store;

    logic        clk;
    logic        rst;
    logic        en_write;
    logic [31:0] addr_first;
    logic [31:0] addr_last;
    logic        flush;
    logic [31:0] cur_addr;
    logic        in_range;
    logic        is_first;
    logic [3:0]  count;
    logic        full;
    logic        drop;
    logic        overwrite;

    int checks = 0;
    int errors = 0;

    interval_store #(.DEPTH(8), .ADDR_W(32)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .en_write_i     (en_write),
        .addr_first_i   (addr_first),
        .addr_last_i    (addr_last),
        .flush_i        (flush),
        .current_addr_i (cur_addr),
        .addr_in_range_o(in_range),
        .addr_is_first_o(is_first),
        .count_o        (count),
        .full_o         (full),
        .drop_o         (drop),
        .overwrite_o    (overwrite)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [31:0] f, input logic [31:0] l);
        en_write   = 1'b1;
        addr_first = f;
        addr_last  = l;
        tick();
        en_write = 1'b0;
    endtask

    task automatic query(input logic [31:0] a);
        cur_addr = a;
        #1;
    endtask

    initial begin
        rst = 1'b1; en_write = 1'b0; flush = 1'b0;
        addr_first = 32'h0; addr_last = 32'h0; cur_addr = 32'h0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        query(32'h0000_1000);
        chk("rst_in_range", {31'd0, in_range}, 32'd0);
        chk("rst_is_first", {31'd0, is_first}, 32'd0);
        chk("rst_count", {28'd0, count}, 32'd0);
        chk("rst_full", {31'd0, full}, 32'd0);
        chk("rst_drop", {31'd0, drop}, 32'd0);
        chk("rst_overwrite", {31'd0, overwrite}, 32'd0);

        // Write latency: same-cycle query sees pre-write contents
        en_write = 1'b1; addr_first = 32'h0000_1000; addr_last = 32'h0000_1010;
        query(32'h0000_1008);
        chk("same_cycle_miss", {31'd0, in_range}, 32'd0);
        tick();
        en_write = 1'b0;
        chk("count_one", {28'd0, count}, 32'd1);
        query(32'h0000_1008); chk("hit_mid", {31'd0, in_range}, 32'd1);
        query(32'h0000_1010); chk("hit_last", {31'd0, in_range}, 32'd1);
        query(32'h0000_1011); chk("miss_after", {31'd0, in_range}, 32'd0);
        query(32'h0000_0FFF);
        chk("is_first_before", {31'd0, is_first}, 32'd1);
        chk("in_range_before", {31'd0, in_range}, 32'd0);

        // Plain flush
        flush = 1'b1; tick(); flush = 1'b0;
        chk("flush_count", {28'd0, count}, 32'd0);
        query(32'h0000_1008); chk("flush_miss", {31'd0, in_range}, 32'd0);

        // Fill to DEPTH
        for (int i = 0; i < 8; i++) do_write(32'(i) << 8, (32'(i) << 8) + 32'hF);
        chk("fill_count", {28'd0, count}, 32'd8);
        chk("fill_full", {31'd0, full}, 32'd1);
        chk("fill_no_overwrite", {31'd0, overwrite}, 32'd0);

        // Overwrite oldest; oldest still hits in the write cycle
        en_write = 1'b1; addr_first = 32'h0000_2000; addr_last = 32'h0000_200F;
        query(32'h0000_0005); chk("evictee_hits_pre", {31'd0, in_range}, 32'd1);
        tick(); en_write = 1'b0;
        chk("overwrite_pulse", {31'd0, overwrite}, 32'd1);
        chk("overwrite_count", {28'd0, count}, 32'd8);
        query(32'h0000_0005); chk("evicted_miss", {31'd0, in_range}, 32'd0);
        query(32'h0000_2005); chk("new_hit", {31'd0, in_range}, 32'd1);
        query(32'h0000_0105); chk("second_kept", {31'd0, in_range}, 32'd1);
        tick();
        chk("overwrite_one_cycle", {31'd0, overwrite}, 32'd0);

        // Malformed write
        do_write(32'h0000_3010, 32'h0000_3000);
        chk("drop_pulse", {31'd0, drop}, 32'd1);
        chk("drop_count", {28'd0, count}, 32'd8);
        chk("drop_no_overwrite", {31'd0, overwrite}, 32'd0);
        query(32'h0000_3005); chk("drop_miss", {31'd0, in_range}, 32'd0);
        query(32'h0000_0105); chk("drop_no_evict", {31'd0, in_range}, 32'd1);
        tick();
        chk("drop_one_cycle", {31'd0, drop}, 32'd0);

        // Duplicate on consecutive cycles
        flush = 1'b1; tick(); flush = 1'b0;
        do_write(32'h0000_1000, 32'h0000_1010);
        do_write(32'h0000_1000, 32'h0000_1010);
        chk("dup_count", {28'd0, count}, 32'd1);
        chk("dup_no_drop", {31'd0, drop}, 32'd0);
        // Single-byte interval is legal
        do_write(32'h0000_5000, 32'h0000_5000);
        chk("single_byte_count", {28'd0, count}, 32'd2);
        query(32'h0000_5000); chk("single_byte_hit", {31'd0, in_range}, 32'd1);
        do_write(32'h0000_6000, 32'h0000_600F);
        chk("three_count", {28'd0, count}, 32'd3);

        // Flush beats simultaneous write
        flush = 1'b1; en_write = 1'b1; addr_first = 32'h0000_4000; addr_last = 32'h0000_4003;
        tick();
        flush = 1'b0; en_write = 1'b0;
        chk("flushw_count", {28'd0, count}, 32'd0);
        chk("flushw_full", {31'd0, full}, 32'd0);
        chk("flushw_drop", {31'd0, drop}, 32'd0);
        chk("flushw_overwrite", {31'd0, overwrite}, 32'd0);
        query(32'h0000_4001); chk("flushw_miss_new", {31'd0, in_range}, 32'd0);
        query(32'h0000_1005); chk("flushw_miss_old", {31'd0, in_range}, 32'd0);
        query(32'h0000_3FFF); chk("flushw_no_first", {31'd0, is_first}, 32'd0);

        // Next write lands in entry 0: it must be the first evicted after refilling
        do_write(32'h0000_7000, 32'h0000_7003);
        chk("after_flush_count", {28'd0, count}, 32'd1);
        for (int i = 0; i < 7; i++) do_write(32'h0000_8000 + 32'(i) * 32'h10, 32'h0000_8003 + 32'(i) * 32'h10);
        chk("refill_full", {31'd0, full}, 32'd1);
        do_write(32'h0000_9000, 32'h0000_9003);
        query(32'h0000_7001); chk("entry0_evicted", {31'd0, in_range}, 32'd0);
        query(32'h0000_8001); chk("entry1_kept", {31'd0, in_range}, 32'd1);

        // Wrap of addr+1: evicts entry 1, stores [0,3]
        do_write(32'h0000_0000, 32'h0000_0003);
        query(32'hFFFF_FFFF);
        chk("wrap_is_first", {31'd0, is_first}, 32'd1);
        chk("wrap_in_range", {31'd0, in_range}, 32'd0);
        query(32'h0000_8001); chk("entry1_evicted", {31'd0, in_range}, 32'd0);

        // Asynchronous reset mid-cycle
        query(32'h0000_0001); chk("pre_rst_hit", {31'd0, in_range}, 32'd1);
        rst = 1'b1;
        #1;
        chk("async_rst_in_range", {31'd0, in_range}, 32'd0);
        chk("async_rst_count", {28'd0, count}, 32'd0);
        chk("async_rst_full", {31'd0, full}, 32'd0);
        tick();
        rst = 1'b0;
        query(32'hFFFF_FFFF); chk("post_rst_is_first", {31'd0, is_first}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
